// File: rtl/aes128_package.sv
// Shared types and constants for the share_unmask block.
package aes128_package;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } share_unmask_state_t;

  // Supported range of Boolean share counts.
  localparam int unsigned SHARE_UNMASK_MIN_SHARES = 2;
  localparam int unsigned SHARE_UNMASK_MAX_SHARES = 5;

endpackage

// File: rtl/share_unmask_reg.sv
// Enable/clear register used to capture the share word.
module share_unmask_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear wins over load; otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/share_unmask.sv
// Recombines a Boolean-shared word by folding one share per cycle.
// Optional build macro: SHARE_UNMASK_CLEAR_EN zeroes the share register and
// accumulator when a word leaves DONE.
//
// state    | meaning
// ST_IDLE  | ready for a new shared word
// ST_ACCUM | folding share[idx] into acc, one share per cycle
// ST_DONE  | acc holds the unmasked word, waiting for in_ready
module share_unmask
  import aes128_package::*;
#(
  parameter int unsigned NUM_SHARES = 2,
  parameter int unsigned BIT_WIDTH  = 2
) (
  input  logic                                 in_clock,
  input  logic                                 in_reset,
  input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] in_shares,
  input  logic                                 in_valid,
  output logic                                 out_ready,
  output logic [BIT_WIDTH-1:0]                 out_value,
  output logic                                 out_valid,
  input  logic                                 in_ready
);

  localparam int unsigned IDX_W = $clog2(NUM_SHARES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SHARES - 1);

  if (NUM_SHARES < SHARE_UNMASK_MIN_SHARES || NUM_SHARES > SHARE_UNMASK_MAX_SHARES) begin : g_bad_shares
    $error("share_unmask: NUM_SHARES must be 2..5");
  end

  share_unmask_state_t                  state;
  share_unmask_state_t                  state_nxt;
  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] share_q;
  logic [BIT_WIDTH-1:0]                 acc;
  logic [IDX_W-1:0]                     idx;
  logic                                 accept;
  logic                                 last_fold;
  logic                                 done_exit;
  logic                                 wipe;

  assign out_ready = (state == ST_IDLE) && !in_reset;
  assign accept    = in_valid && out_ready;
  assign last_fold = (state == ST_ACCUM) && (idx == IDX_LAST);
  assign done_exit = (state == ST_DONE) && in_ready;

`ifdef SHARE_UNMASK_CLEAR_EN
  assign wipe = done_exit;
`else
  assign wipe = 1'b0;
`endif

  assign out_valid = (state == ST_DONE);
  assign out_value = out_valid ? acc : '0;

  share_unmask_reg #(
    .WIDTH(NUM_SHARES * BIT_WIDTH)
  ) u_share_reg (
    .clk(in_clock),
    .rst(in_reset),
    .en (accept),
    .clr(wipe),
    .d  (in_shares),
    .q  (share_q)
  );

  // State register.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept)    state_nxt = ST_ACCUM;
      ST_ACCUM: if (last_fold) state_nxt = ST_DONE;
      ST_DONE:  if (in_ready)  state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  // Accumulator and share index; idx saturates at the last share.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      acc <= '0;
      idx <= '0;
    end else if (accept) begin
      acc <= in_shares[0];
      idx <= IDX_W'(1);
    end else if (state == ST_ACCUM) begin
      acc <= acc ^ share_q[idx];
      if (!last_fold) begin
        idx <= idx + IDX_W'(1);
      end
    end else if (wipe) begin
      acc <= '0;
    end
  end

endmodule

// File: tb/tb_share_unmask.sv
// Randomized and directed bench for share_unmask (3 shares of 8 bits).
module tb_share_unmask;

  localparam int N = 3;
  localparam int W = 8;

  logic                in_clock = 1'b0;
  logic                in_reset;
  logic [N-1:0][W-1:0] in_shares;
  logic                in_valid;
  logic                in_ready;
  logic                out_ready;
  logic                out_valid;
  logic [W-1:0]        out_value;

  always #5 in_clock = ~in_clock;

  share_unmask #(
    .NUM_SHARES(N),
    .BIT_WIDTH (W)
  ) dut (
    .in_clock (in_clock),
    .in_reset (in_reset),
    .in_shares(in_shares),
    .in_valid (in_valid),
    .out_ready(out_ready),
    .out_value(out_value),
    .out_valid(out_valid),
    .in_ready (in_ready)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Reference: a word is busy from accept until its output handshake; the
  // output is the XOR of all shares and appears N cycles after the accept cycle.
  bit                  m_busy = 1'b0;
  int                  m_age  = 0;
  logic [W-1:0]        m_val  = '0;
  logic [N-1:0][W-1:0] m_sh   = '0;
  int                  cyc    = 0;
  logic                last_rdy;
  logic [W-1:0]        last_out;
  int                  acc_cycles[$];

  function automatic logic [W-1:0] xor_all(input logic [N-1:0][W-1:0] s);
    logic [W-1:0] r = '0;
    for (int i = 0; i < N; i++) r = r ^ s[i];
    return r;
  endfunction

  task automatic step(input bit v, input bit r, input bit rs, input logic [N-1:0][W-1:0] sh);
    bit           e_rdy;
    bit           e_vld;
    logic [W-1:0] e_out;
    in_valid  = v;
    in_ready  = r;
    in_reset  = rs;
    in_shares = sh;
    #2;
    if (rs) m_busy = 1'b0;
    e_rdy = !m_busy && !rs;
    e_vld = m_busy && (m_age >= N);
    e_out = e_vld ? m_val : '0;
    check_eq("out_ready", 32'(out_ready), 32'(e_rdy));
    check_eq("out_valid", 32'(out_valid), 32'(e_vld));
    check_eq("out_value", 32'(out_value), 32'(e_out));
    last_rdy = out_ready;
    last_out = out_value;
    if (out_ready && v) acc_cycles.push_back(cyc);
    @(posedge in_clock);
    #1;
    if (!rs) begin
      if (!m_busy) begin
        if (v) begin
          m_busy = 1'b1;
          m_age  = 1;
          m_val  = xor_all(sh);
          m_sh   = sh;
        end
      end else if (e_vld && r) begin
        m_busy = 1'b0;
      end else begin
        m_age++;
      end
    end
    cyc++;
  endtask

  function automatic logic [N-1:0][W-1:0] rnd_sh();
    return (N*W)'($urandom);
  endfunction

  initial begin
    logic [N-1:0][W-1:0] sh;
    in_reset  = 1'b1;
    in_valid  = 1'b0;
    in_ready  = 1'b0;
    in_shares = '0;
    repeat (2) @(posedge in_clock);
    #1;

    // Reset state.
    step(1'b1, 1'b1, 1'b1, rnd_sh());
    check_eq("rst_acc", 32'(dut.acc), 32'd0);
    check_eq("rst_share", 32'(dut.share_q), 32'd0);
    check_eq("rst_idx", 32'(dut.idx), 32'd0);

    // Three shares folding to 0xC3, then backpressure with in_valid high.
    sh = {8'h5A, 8'hA5, 8'h3C};
    step(1'b1, 1'b1, 1'b0, sh);
    step(1'b0, 1'b1, 1'b0, rnd_sh());
    step(1'b0, 1'b1, 1'b0, rnd_sh());
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, rnd_sh());
      check_eq("bp_value", 32'(last_out), 32'h0000_00C3);
      check_eq("bp_not_ready", 32'(last_rdy), 32'd0);
    end
    step(1'b0, 1'b1, 1'b0, rnd_sh());
    check_eq("hs_value", 32'(last_out), 32'h0000_00C3);
    step(1'b0, 1'b0, 1'b0, rnd_sh());
`ifdef SHARE_UNMASK_CLEAR_EN
    check_eq("post_acc", 32'(dut.acc), 32'd0);
    check_eq("post_share", 32'(dut.share_q), 32'd0);
`else
    check_eq("post_acc", 32'(dut.acc), 32'(m_val));
    check_eq("post_share", 32'(dut.share_q), 32'(m_sh));
`endif

    // Reset during ACCUM aborts the word; next word folds to 0x07.
    step(1'b1, 1'b1, 1'b0, rnd_sh());
    step(1'b0, 1'b1, 1'b0, rnd_sh());
    step(1'b0, 1'b1, 1'b1, rnd_sh());
    check_eq("abort_acc", 32'(dut.acc), 32'd0);
    step(1'b0, 1'b1, 1'b0, rnd_sh());
    step(1'b1, 1'b1, 1'b0, {8'h04, 8'h02, 8'h01});
    step(1'b0, 1'b1, 1'b0, rnd_sh());
    step(1'b0, 1'b1, 1'b0, rnd_sh());
    step(1'b0, 1'b1, 1'b0, rnd_sh());
    check_eq("word_07", 32'(last_out), 32'h0000_0007);

    // Back-to-back words with in_valid held high.
    acc_cycles.delete();
    for (int i = 0; i < 17; i++) step(1'b1, 1'b1, 1'b0, rnd_sh());
    check_eq("b2b_count", 32'(acc_cycles.size()), 32'd5);
    for (int i = 1; i < acc_cycles.size(); i++)
      check_eq("b2b_spacing", 32'(acc_cycles[i] - acc_cycles[i-1]), 32'(N + 1));

    // Random traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 99) < 2), rnd_sh());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/share_unmask.md
SHARE_UNMASK -- requirements
Module: share_unmask

Interface
REQ-001 SHALL have parameter NUM_SHARES, default 2: number of Boolean shares per input word; supported values 2..5.
REQ-002 SHALL have parameter BIT_WIDTH, default 2: bits per share and per output word.
REQ-003 SHALL have port in_clock  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port in_reset  input  1: reset, asynchronous and active-high.
REQ-005 SHALL have port in_shares  input  NUM_SHARES x BIT_WIDTH: shared word; index 0 is share 0.
REQ-006 SHALL have port in_valid  input  1: upstream presents in_shares.
REQ-007 SHALL have port out_ready  output  1: block accepts in_shares this cycle.
REQ-008 SHALL have port out_value  output  BIT_WIDTH: recombined, unmasked word.
REQ-009 SHALL have port out_valid  output  1: out_value is valid.
REQ-010 SHALL have port in_ready  input  1: downstream accepts out_value.

Function
REQ-011 SHALL implement the FSM IDLE -> ACCUM -> DONE -> IDLE.
REQ-012 SHALL drive out_ready = 1 only in IDLE.
- Accept occurs on in_valid & out_ready.
REQ-013 On accept, SHALL capture all shares into a share register, set acc = share[0] and idx = 1, and enter ACCUM.
REQ-014 In ACCUM, SHALL update acc ^= share[idx] and idx += 1 each cycle.
- Exactly one share is folded per cycle, so no combinational XOR tree spans all shares.
REQ-015 SHALL enter DONE on the edge that folds share[NUM_SHARES-1].
REQ-016 SHALL drive out_valid = 1 only in DONE, and out_value = acc only in DONE; otherwise out_value SHALL be zero.
REQ-017 Latency SHALL be exactly NUM_SHARES cycles from the accept edge to the first cycle with out_valid = 1.
REQ-018 In DONE, SHALL hold out_value stable while in_ready = 0.
- Unbounded backpressure is permitted.
REQ-019 On DONE & in_ready, SHALL return to IDLE.
- No new word is accepted in the same cycle.
- Throughput is one word per NUM_SHARES+1 cycles minimum.
REQ-020 SHALL ignore in_shares and in_valid in ACCUM and DONE; upstream holds data until out_ready.
REQ-021 idx SHALL be ceil(log2(NUM_SHARES)) bits wide and never exceed NUM_SHARES-1.
REQ-022 Any unsupported NUM_SHARES SHALL cause an elaboration error.

Reset
REQ-023 While in_reset = 1, SHALL hold the FSM in IDLE with share register, acc and idx zero, out_valid = 0, out_value = 0 and out_ready = 0.
REQ-024 Reset asserted mid-ACCUM or mid-DONE SHALL abort the word with no output produced.
- The first accept after reset deassertion is allowed on the following edge.

Configuration
REQ-025 With SHARE_UNMASK_CLEAR_EN defined, SHALL zero the share register and acc on the DONE -> IDLE transition, so no share or plaintext value persists between words.
REQ-026 Without SHARE_UNMASK_CLEAR_EN, those registers SHALL retain stale values until the next accept.
- Functional output is identical in both builds.

Structure
REQ-027 SHALL place the FSM state enum (share_unmask_state_t) and the supported-share-count check constant in aes128_package.
REQ-028 SHALL use the existing register module for the share capture register; no other sub-module.

Verification
REQ-029 NUM_SHARES=3, BIT_WIDTH=8, shares {0x3C,0xA5,0x5A}, in_ready=1 -> out_value=0xC3 with out_valid high exactly 3 cycles after accept, for one cycle.
REQ-030 NUM_SHARES=2, BIT_WIDTH=8, shares {0xFF,0x0F} -> out_value=0xF0 at latency 2; out_ready low from accept until one cycle after the DONE handshake.
REQ-031 Backpressure: in_ready=0 for 5 cycles in DONE -> out_valid and out_value (0xC3) stable; in_valid held high meanwhile is not accepted.
REQ-032 Reset asserted during ACCUM -> out_valid never rises for that word; all outputs 0; next word {0x01,0x02,0x04} -> 0x07.
REQ-033 SHARE_UNMASK_CLEAR_EN build: after DONE handshake, internal acc and share register read 0; without the macro they retain the last values.
REQ-034 Back-to-back words with in_valid held high -> accepts spaced exactly NUM_SHARES+1 cycles apart, with correct values for each word.
